// File: rtl/pb_debounce_pkg.sv
// Shared constants and helpers for the push-button debounce block.
// Imported by the channel and top modules.
package pb_debounce_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int SYNC_STAGES_DEF     = 2;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/pb_debounce_ch.sv
// One button channel: synchroniser, stability counter, debounced level,
// press/release pulses and press-toggled latch.
module pb_debounce_ch
  import pb_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic press,
  output logic rel,
  output logic toggle
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s;
  logic                   diff;
  logic                   done;

  assign s    = sync[SYNC_STAGES-1];
  assign diff = s ^ level;
  assign done = diff && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= '0;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
      toggle <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      // any sample matching the level (a bounce) restarts the count
      if (!diff || done) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (done) begin
        level <= s;
      end
      press <= done & s;
      rel   <= done & ~s;
      if (done && s) begin
        toggle <= ~toggle;
      end
    end
  end

endmodule

// File: rtl/pb_debounce.sv
// Push-button conditioning: polarity fix-up then N independent
// debounce channels with level, pulse and toggle outputs.
module pb_debounce
  import pb_debounce_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_toggle
);

  logic [N_BTN-1:0] btn_in;

  // internally "pressed" is always 1
  assign btn_in = btn_raw ^ {N_BTN{BTN_ACTIVE_LOW}};

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    pb_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .din   (btn_in[i]),
      .level (btn_level[i]),
      .press (btn_press[i]),
      .rel   (btn_release[i]),
      .toggle(btn_toggle[i])
    );
  end

endmodule

// File: doc/pb_debounce.md
Name: pb_debounce

Overview:
- Upstream conditioning stage for the board push buttons.
- Synchronises the N raw, asynchronous, bouncy button inputs to the system clock and debounces each one independently.
- Outputs per button: a stable level, one-cycle press and release pulses, and a press-toggled latch.
- btn_level or btn_toggle drives the push_button inputs of the switch/LED group gating stage.

Parameters:
- N_BTN, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before the output changes (10 ms at 100 MHz). Legal range >= 1.
- SYNC_STAGES, 2, flip-flops in the input synchroniser. Legal range >= 2.
- BTN_ACTIVE_LOW, 0, when 1 the raw inputs are inverted before synchronisation, so "pressed" is always 1 internally.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  N_BTN  raw pad inputs, asynchronous to clk.
- btn_level  out  N_BTN  debounced button state, 1 = pressed.
- btn_press  out  N_BTN  one-cycle pulse on a debounced 0->1 transition.
- btn_release  out  N_BTN  one-cycle pulse on a debounced 1->0 transition.
- btn_toggle  out  N_BTN  flips on every debounced press.

Behaviour:
- One clock domain; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset (rst=1 at an edge) clears the following to 0 at that edge, for all channels:
  - synchroniser flops;
  - counters;
  - btn_level, btn_press, btn_release, btn_toggle.
- Reset mid-count or mid-bounce abandons the count. The first post-reset sample is treated as a fresh mismatch against level 0.
- Per-channel datapath (channels fully independent):
  - Polarity: in = btn_raw[i] ^ BTN_ACTIVE_LOW.
  - Synchroniser: SYNC_STAGES-deep shift register; s = last stage.
  - Counter cnt has width $clog2(DEBOUNCE_CYCLES+1).
  - If s == btn_level: cnt <= 0.
  - If s != btn_level and cnt == DEBOUNCE_CYCLES-1: btn_level <= s, cnt <= 0.
  - Otherwise, if s != btn_level: cnt <= cnt+1.
  - Any single-cycle return to s == btn_level (a bounce) restarts the count from 0. The counter never wraps.
- Latency: a clean raw step appears on btn_level exactly SYNC_STAGES + DEBOUNCE_CYCLES clock edges after the first edge that samples the new value.
- Pulses and toggle:
  - btn_press is registered. It is 1 for exactly the one cycle in which btn_level first reads 1 after a 0->1 update, and 0 otherwise.
  - btn_release is the mirror for 1->0.
  - btn_press and btn_release are never both 1 on a channel.
  - btn_toggle <= ~btn_toggle at the same edge that sets btn_press, so the toggle change is visible in the same cycle as the pulse.
- Glitches shorter than DEBOUNCE_CYCLES consecutive synchronised cycles produce no output activity.
- Simultaneous events on different channels are handled independently in the same cycle.
- DEBOUNCE_CYCLES = 1: btn_level follows s with one cycle delay. This is legal.
- All outputs are registered; there are no combinational paths from btn_raw to any output.

Decomposition:
- Package pb_debounce_pkg holds:
  - default constants DEBOUNCE_CYCLES_DEF and SYNC_STAGES_DEF;
  - function cnt_width(int cycles) returning $clog2(cycles+1).
- Sub-module pb_debounce_ch: one channel containing the synchroniser, counter, level, pulses and toggle, with scalar ports.
- Top pb_debounce instantiates N_BTN copies in a generate loop and applies BTN_ACTIVE_LOW.

Test Plan (bench parameters: DEBOUNCE_CYCLES=4, SYNC_STAGES=2, N_BTN=4):
- Reset: rst=1 for 3 cycles with btn_raw=4'b1111 -> all outputs 0 during reset. After rst falls, btn_level=4'b1111 exactly 6 edges later, with one btn_press pulse per channel and btn_toggle=4'b1111.
- Clean press on ch0: btn_raw[0] 0->1 held -> btn_level[0]=1 after 6 edges; btn_press[0]=1 for one cycle; btn_toggle[0]=1. Other channels unchanged.
- Bounce on ch1: raw pattern 1,0,1,1,0,1 (one per cycle), then held 1 -> no output change during the bounce. btn_level[1]=1 six edges after the final 0->1, with a single btn_press.
- Short glitch on ch2: 3-cycle high pulse -> btn_level, btn_press and btn_toggle stay 0 throughout.
- Press/release/press on ch3 with 20-cycle holds -> pulse sequence press, release, press; btn_toggle[3] goes 0->1->1->0 across the sequence.
- Reset mid-count: ch0 raw high, rst=1 asserted 3 edges into the count -> counters and outputs cleared. After rst falls, btn_level[0]=1 a full 6 edges later, with no early change.
- Active-low build (BTN_ACTIVE_LOW=1): btn_raw held 4'b1111 -> btn_level stays 0; driving 4'b1110 -> btn_level=4'b0001 after 6 edges.
